latch_array_ctrl: RTL

Request-level access controller sitting directly upstream of address_decoder in the NAND-latch bitcell memory.
Accepts one read/write request at a time over a valid/ready handshake, then sequences the decoder inputs (adr, select) through setup, pulse and hold phases so the 8 latch words are never glitched.
Captures read data from the array and returns it through a response handshake.

---
 rtl/latch_array_ctrl_pkg.sv | 25 ++
 rtl/latch_array_ctrl_if.sv | 34 +++
 rtl/latch_array_ctrl_phase_timer.sv | 36 +++
 rtl/latch_array_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/latch_array_ctrl_pkg.sv
// Shared types and timing defaults for the latch-array access controller.
// Phase counts are cycle counts; the phase timer is loaded with count-1.
package latch_ctrl_pkg;

    localparam int CNT_W         = 4;
    localparam int ADDR_W_DEF    = 3;
    localparam int DATA_W_DEF    = 8;
    localparam int SETUP_CYC_DEF = 1;
    localparam int PULSE_CYC_DEF = 2;
    localparam int HOLD_CYC_DEF  = 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        RESP  = 3'd4
    } state_e;

    typedef struct packed {
        logic [2:0]       state;
        logic [CNT_W-1:0] cnt;
    } dbg_t;

endpackage

// File: rtl/latch_array_ctrl_if.sv
// Request/response handshakes plus the decoder/array side of the controller.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
// the producer holds valid and its payload stable until that edge.
interface latch_array_ctrl_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] adr;
    logic              select;
    logic              arr_we;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;
    logic              busy;

    // Requester and latch array side.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, arr_rdata,
        input  req_ready, rsp_valid, rsp_rdata, adr, select, arr_we, arr_wdata, busy
    );

    // Controller side.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, arr_rdata,
        output req_ready, rsp_valid, rsp_rdata, adr, select, arr_we, arr_wdata, busy
    );
endinterface

// File: rtl/latch_array_ctrl_phase_timer.sv
// Loadable down-counter that times the setup, pulse and hold phases.
// Load wins over decrement; the count parks at zero.
module phase_timer
    import latch_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] value_o,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o = cnt_q;
    assign zero_o  = (cnt_q == '0);
endmodule

// File: rtl/latch_array_ctrl.sv
// Single-outstanding access controller for the NAND-latch word array: sequences adr/select
// through setup, pulse and hold so the latches never see a glitching select or address.
module latch_array_ctrl
    import latch_ctrl_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int SETUP_CYC = SETUP_CYC_DEF,
    parameter int PULSE_CYC = PULSE_CYC_DEF,
    parameter int HOLD_CYC  = HOLD_CYC_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    latch_array_ctrl_if.slave   bus,
    output dbg_t                dbg_o
);
    localparam logic [2:0] S_IDLE  = 3'(IDLE);
    localparam logic [2:0] S_SETUP = 3'(SETUP);
    localparam logic [2:0] S_PULSE = 3'(PULSE);
    localparam logic [2:0] S_HOLD  = 3'(HOLD);
    localparam logic [2:0] S_RESP  = 3'(RESP);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              select_q, select_d;
    logic              arr_we_q, arr_we_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              req_ready_q;
    logic              busy_q;

    logic              tmr_load;
    logic              tmr_en;
    logic [CNT_W-1:0]  tmr_load_val;
    logic [CNT_W-1:0]  tmr_value;
    logic              tmr_zero;

    phase_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .en_i       (tmr_en),
        .load_val_i (tmr_load_val),
        .value_o    (tmr_value),
        .zero_o     (tmr_zero)
    );

    // select/arr_we are set and cleared on the same edges that move the FSM, so adr
    // (only loaded in IDLE) is stable for a full SETUP and HOLD phase around the pulse.
    always_comb begin
        state_d      = state_q;
        adr_d        = adr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        select_d     = select_q;
        arr_we_d     = arr_we_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        tmr_load     = 1'b0;
        tmr_en       = 1'b0;
        tmr_load_val = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    state_d      = S_SETUP;
                    adr_d        = bus.req_addr;
                    we_d         = bus.req_we;
                    wdata_d      = bus.req_wdata;
                    tmr_load     = 1'b1;
                    tmr_load_val = SETUP_LD;
                end
            end
            S_SETUP: begin
                if (tmr_zero) begin
                    state_d      = S_PULSE;
                    select_d     = 1'b1;
                    arr_we_d     = we_q;
                    tmr_load     = 1'b1;
                    tmr_load_val = PULSE_LD;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_PULSE: begin
                if (tmr_zero) begin
                    state_d      = S_HOLD;
                    select_d     = 1'b0;
                    arr_we_d     = 1'b0;
                    rsp_rdata_d  = we_q ? wdata_q : bus.arr_rdata;
                    tmr_load     = 1'b1;
                    tmr_load_val = HOLD_LD;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_HOLD: begin
                if (tmr_zero) begin
                    state_d = S_RESP;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_RESP: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                end else if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                select_d    = 1'b0;
                arr_we_d    = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            adr_q       <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            select_q    <= 1'b0;
            arr_we_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            select_q    <= select_d;
            arr_we_q    <= arr_we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            req_ready_q <= (state_d == S_IDLE);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.busy      = busy_q;
    assign bus.adr       = adr_q;
    assign bus.select    = select_q;
    assign bus.arr_we    = arr_we_q;
    assign bus.arr_wdata = wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign dbg_o         = {state_q, tmr_value};
endmodule
